// File: rtl/benes_feeder.sv
// Collects PORT_NUM words into one vector for a Benes network, latches the switch
// configuration, issues one N_VALID pulse per batch and tracks network output timing.
module benes_feeder #(
   parameter int DATA_WIDTH  = 512,
   parameter int PORT_NUM    = 32,
   parameter int SWITCH_NUM  = PORT_NUM/2,
   parameter int STAGE_NUM   = 2*$clog2(PORT_NUM)-1,
   parameter int NET_LATENCY = 2*STAGE_NUM
) (
   input  logic                                   CLK,
   input  logic                                   RST_N,
   input  logic                                   CFG_VALID,
   output logic                                   CFG_READY,
   input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   CFG_SET,
   input  logic                                   S_VALID,
   output logic                                   S_READY,
   input  logic [DATA_WIDTH-1:0]                  S_DATA,
   output logic [0:PORT_NUM-1][DATA_WIDTH-1:0]    N_PORT,
   output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]   N_SWITCH_SET,
   output logic                                   N_VALID,
   output logic                                   OUT_VALID,
   output logic [15:0]                            BATCH_CNT
);

   localparam int                CNT_W     = $clog2(PORT_NUM);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(PORT_NUM-1);

   typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        beat_cnt;
   logic [15:0]             batch_cnt;
   logic [NET_LATENCY-1:0]  vld_pipe;
   logic                    cfg_take;
   logic                    beat_take;

   assign cfg_take  = (state == IDLE) && CFG_VALID;
   assign beat_take = S_READY && S_VALID;

   // CFG_READY is gated by reset because the state register sits in IDLE while reset is held
   always_comb begin
      state_nxt = state;
      CFG_READY = 1'b0;
      S_READY   = 1'b0;
      N_VALID   = 1'b0;
      case (state)
         IDLE: begin
            CFG_READY = RST_N;
            if (CFG_VALID) state_nxt = FILL;
         end
         FILL: begin
            S_READY = 1'b1;
            if (S_VALID && (beat_cnt == LAST_BEAT)) state_nxt = ISSUE;
         end
         ISSUE: begin
            N_VALID   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)         beat_cnt <= '0;
      else if (cfg_take)  beat_cnt <= '0;
      else if (beat_take) beat_cnt <= beat_cnt + 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)        N_SWITCH_SET <= '0;
      else if (cfg_take) N_SWITCH_SET <= CFG_SET;
   end

   // Only the addressed word changes; the rest of the vector keeps its previous contents
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)         N_PORT           <= '0;
      else if (beat_take) N_PORT[beat_cnt] <= S_DATA;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)       batch_cnt <= '0;
      else if (N_VALID) batch_cnt <= batch_cnt + 16'd1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= N_VALID;
         for (int i = 1; i < NET_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   assign OUT_VALID = vld_pipe[NET_LATENCY-1];
   assign BATCH_CNT = batch_cnt;

endmodule

// File: tb/tb_benes_feeder.sv
// Randomized bench for benes_feeder: a batch-level reference model tracks the expected
// port vector, switch set, batch count and N_VALID/OUT_VALID timing.
module tb_benes_feeder;

   localparam int DW  = 512;
   localparam int PN  = 32;
   localparam int SN  = PN/2;
   localparam int SG  = 2*$clog2(PN)-1;
   localparam int LAT = 2*SG;
   localparam int PERIOD_CYC = PN + 2;

   typedef logic [0:SG-1][0:SN-1]  sw_t;
   typedef logic [0:PN-1][DW-1:0]  port_t;

   logic           CLK;
   logic           RST_N;
   logic           CFG_VALID;
   logic           CFG_READY;
   sw_t            CFG_SET;
   logic           S_VALID;
   logic           S_READY;
   logic [DW-1:0]  S_DATA;
   port_t          N_PORT;
   sw_t            N_SWITCH_SET;
   logic           N_VALID;
   logic           OUT_VALID;
   logic [15:0]    BATCH_CNT;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     nv_q[$];
   int     ov_q[$];
   port_t  exp_port;
   sw_t    exp_sw;
   logic [15:0] exp_batch;

   benes_feeder #(
      .DATA_WIDTH(DW), .PORT_NUM(PN), .SWITCH_NUM(SN), .STAGE_NUM(SG), .NET_LATENCY(LAT)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_SET(CFG_SET),
      .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
      .N_PORT(N_PORT), .N_SWITCH_SET(N_SWITCH_SET), .N_VALID(N_VALID),
      .OUT_VALID(OUT_VALID), .BATCH_CNT(BATCH_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (N_VALID)   nv_q.push_back(cyc);
      if (OUT_VALID) ov_q.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic sw_t rand_sw();
      logic [SG*SN-1:0] f;
      for (int i = 0; i < SG*SN; i++) f[i] = 1'($urandom_range(0, 1));
      return f;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_wait(input int n);
      CFG_VALID = 1'b0;
      S_VALID   = 1'b0;
      repeat (n) tick();
   endtask

   // One batch: config cycle, PN accepted beats (with optional gaps), issue cycle.
   task automatic fill_batch(input sw_t cfg, input int gap_pct, input bit simul, input bit seq_data);
      int k;
      CFG_VALID = 1'b1;
      CFG_SET   = cfg;
      S_VALID   = simul;
      S_DATA    = rand_word();
      @(negedge CLK);
      n_checks++;
      if (CFG_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_ready_idle: got %b, required 1", CFG_READY);
      end
      if (simul) begin
         n_checks++;
         if (S_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL s_ready_in_idle: got %b, required 0", S_READY);
         end
      end
      exp_sw = cfg;
      tick();
      k = 0;
      while (k < PN) begin
         S_DATA = seq_data ? DW'(k) : rand_word();
         S_VALID = ($urandom_range(0, 99) >= gap_pct);
         if (simul && k >= 5 && k < 10) begin
            CFG_VALID = 1'b1;
            CFG_SET   = ~cfg;
         end else begin
            CFG_VALID = 1'b0;
            CFG_SET   = rand_sw();
         end
         if (S_VALID) exp_port[k] = S_DATA;
         @(negedge CLK);
         n_checks++;
         if (S_READY !== 1'b1 || N_VALID !== 1'b0 || CFG_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_handshake beat %0d: got s_ready=%b n_valid=%b cfg_ready=%b, required 1 0 0",
                     k, S_READY, N_VALID, CFG_READY);
         end
         if (S_VALID) k++;
         tick();
      end
      S_VALID   = 1'b0;
      CFG_VALID = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (N_VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL n_valid_issue: got %b, required 1", N_VALID);
      end
      n_checks++;
      if (N_PORT !== exp_port) begin
         n_fail++;
         for (int i = 0; i < PN; i++)
            if (N_PORT[i] !== exp_port[i]) begin
               $display("FAIL n_port[%0d]: got %h, required %h", i, N_PORT[i], exp_port[i]);
               break;
            end
      end
      n_checks++;
      if (N_SWITCH_SET !== exp_sw) begin
         n_fail++;
         $display("FAIL n_switch_set: got %h, required %h", N_SWITCH_SET, exp_sw);
      end
      exp_batch = exp_batch + 16'd1;
      tick();
      @(negedge CLK);
      n_checks++;
      if (N_VALID !== 1'b0 || BATCH_CNT !== exp_batch || CFG_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL post_issue: got n_valid=%b batch_cnt=%h cfg_ready=%b, required 0 %h 1",
                  N_VALID, BATCH_CNT, CFG_READY, exp_batch);
      end
      tick();
   endtask

   task automatic test_reset();
      RST_N     = 1'b0;
      CFG_VALID = 1'b1;
      CFG_SET   = rand_sw();
      S_VALID   = 1'b1;
      S_DATA    = rand_word();
      repeat (3) tick();
      @(negedge CLK);
      n_checks++;
      if (CFG_READY !== 1'b0 || S_READY !== 1'b0 || N_VALID !== 1'b0 || OUT_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got cfg_ready=%b s_ready=%b n_valid=%b out_valid=%b, required 0 0 0 0",
                  CFG_READY, S_READY, N_VALID, OUT_VALID);
      end
      n_checks++;
      if (BATCH_CNT !== 16'h0000 || N_PORT !== '0 || N_SWITCH_SET !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got batch_cnt=%h switch_set=%h, required 0 and all-zero port vector",
                  BATCH_CNT, N_SWITCH_SET);
      end
      CFG_VALID = 1'b0;
      S_VALID   = 1'b0;
      RST_N     = 1'b1;
      tick();
      @(negedge CLK);
      n_checks++;
      if (CFG_READY !== 1'b1 || S_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_idle: got cfg_ready=%b s_ready=%b, required 1 0", CFG_READY, S_READY);
      end
      exp_port  = '0;
      exp_sw    = '0;
      exp_batch = 16'h0000;
      tick();
   endtask

   task automatic test_basic();
      idle_wait(LAT + 4);
      nv_q.delete();
      ov_q.delete();
      fill_batch('1, 0, 1'b0, 1'b1);
      idle_wait(LAT + 4);
      n_checks++;
      if (BATCH_CNT !== 16'd1) begin
         n_fail++;
         $display("FAIL basic_batch_cnt: got %0d, required 1", BATCH_CNT);
      end
      n_checks++;
      if (nv_q.size() != 1 || ov_q.size() != 1) begin
         n_fail++;
         $display("FAIL basic_pulse_count: got n_valid=%0d out_valid=%0d, required 1 1", nv_q.size(), ov_q.size());
      end else if (ov_q[0] - nv_q[0] != LAT) begin
         n_fail++;
         $display("FAIL basic_out_latency: got %0d, required %0d", ov_q[0] - nv_q[0], LAT);
      end
   endtask

   task automatic test_backpressure();
      idle_wait(LAT + 4);
      nv_q.delete();
      fill_batch(rand_sw(), 50, 1'b0, 1'b1);
      n_checks++;
      if (nv_q.size() != 1) begin
         n_fail++;
         $display("FAIL bp_n_valid_count: got %0d, required 1", nv_q.size());
      end
   endtask

   task automatic test_simultaneous();
      idle_wait(LAT + 4);
      fill_batch(rand_sw(), 20, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_fill();
      idle_wait(LAT + 4);
      nv_q.delete();
      ov_q.delete();
      CFG_VALID = 1'b1;
      CFG_SET   = rand_sw();
      tick();
      CFG_VALID = 1'b0;
      for (int k = 0; k < 10; k++) begin
         S_VALID = 1'b1;
         S_DATA  = rand_word();
         tick();
      end
      #2 RST_N = 1'b0;
      #1;
      n_checks++;
      if (CFG_READY !== 1'b0 || S_READY !== 1'b0 || N_VALID !== 1'b0 || OUT_VALID !== 1'b0 ||
          BATCH_CNT !== 16'h0000 || N_PORT !== '0 || N_SWITCH_SET !== '0) begin
         n_fail++;
         $display("FAIL midfill_async_clear: got cfg_ready=%b s_ready=%b n_valid=%b out_valid=%b batch_cnt=%h",
                  CFG_READY, S_READY, N_VALID, OUT_VALID, BATCH_CNT);
      end
      S_VALID = 1'b0;
      repeat (2) tick();
      @(negedge CLK);
      RST_N = 1'b1;
      exp_port  = '0;
      exp_sw    = '0;
      exp_batch = 16'h0000;
      idle_wait(LAT + 10);
      n_checks++;
      if (nv_q.size() != 0 || ov_q.size() != 0) begin
         n_fail++;
         $display("FAIL midfill_no_pulse: got n_valid=%0d out_valid=%0d, required 0 0", nv_q.size(), ov_q.size());
      end
      fill_batch(rand_sw(), 25, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] dat [0:3*PERIOD_CYC-1];
      sw_t           cfgs[0:3*PERIOD_CYC-1];
      int            ph;
      int            b;
      idle_wait(LAT + 4);
      nv_q.delete();
      ov_q.delete();
      for (int t = 0; t < 3*PERIOD_CYC; t++) begin
         ph = t % PERIOD_CYC;
         b  = t / PERIOD_CYC;
         dat[t]    = rand_word();
         cfgs[t]   = rand_sw();
         CFG_VALID = 1'b1;
         CFG_SET   = cfgs[t];
         S_VALID   = 1'b1;
         S_DATA    = dat[t];
         @(negedge CLK);
         if (ph == 0) begin
            n_checks++;
            if (CFG_READY !== 1'b1 || S_READY !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_cfg_phase batch %0d: got cfg_ready=%b s_ready=%b, required 1 0", b, CFG_READY, S_READY);
            end
         end else if (ph == PERIOD_CYC - 1) begin
            for (int k = 0; k < PN; k++) exp_port[k] = dat[b*PERIOD_CYC + 1 + k];
            exp_sw = cfgs[b*PERIOD_CYC];
            n_checks++;
            if (N_VALID !== 1'b1 || N_PORT !== exp_port || N_SWITCH_SET !== exp_sw || BATCH_CNT !== exp_batch) begin
               n_fail++;
               $display("FAIL b2b_issue batch %0d: got n_valid=%b batch_cnt=%h port_ok=%b sw_ok=%b, required 1 %h 1 1",
                        b, N_VALID, BATCH_CNT, N_PORT === exp_port, N_SWITCH_SET === exp_sw, exp_batch);
            end
            exp_batch = exp_batch + 16'd1;
         end else begin
            n_checks++;
            if (S_READY !== 1'b1 || N_VALID !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_fill batch %0d phase %0d: got s_ready=%b n_valid=%b, required 1 0",
                        b, ph, S_READY, N_VALID);
            end
         end
         tick();
      end
      idle_wait(LAT + 4);
      n_checks++;
      if (BATCH_CNT !== exp_batch) begin
         n_fail++;
         $display("FAIL b2b_batch_cnt: got %0d, required %0d", BATCH_CNT, exp_batch);
      end
      n_checks++;
      if (nv_q.size() != 3 || ov_q.size() != 3) begin
         n_fail++;
         $display("FAIL b2b_pulse_count: got n_valid=%0d out_valid=%0d, required 3 3", nv_q.size(), ov_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ov_q[i] - nv_q[i] != LAT || (i > 0 && nv_q[i] - nv_q[i-1] != PERIOD_CYC)) begin
               n_fail++;
               $display("FAIL b2b_spacing pulse %0d: got out_lat=%0d gap=%0d, required %0d %0d",
                        i, ov_q[i] - nv_q[i], (i > 0) ? nv_q[i] - nv_q[i-1] : PERIOD_CYC, LAT, PERIOD_CYC);
            end
         end
      end
   endtask

   task automatic test_wrap();
      idle_wait(LAT + 4);
      @(negedge CLK);
      force dut.batch_cnt = 16'hFFFF;
      #1 release dut.batch_cnt;
      exp_batch = 16'hFFFF;
      #1;
      n_checks++;
      if (BATCH_CNT !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_preload: got %h, required ffff", BATCH_CNT);
      end
      tick();
      fill_batch(rand_sw(), 10, 1'b0, 1'b0);
      n_checks++;
      if (BATCH_CNT !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_rollover: got %h, required 0000", BATCH_CNT);
      end
   endtask

   initial begin
      RST_N     = 1'b0;
      CFG_VALID = 1'b0;
      CFG_SET   = '0;
      S_VALID   = 1'b0;
      S_DATA    = '0;
      exp_port  = '0;
      exp_sw    = '0;
      exp_batch = 16'h0000;
      test_reset();
      test_basic();
      test_backpressure();
      test_simultaneous();
      test_reset_mid_fill();
      test_back_to_back();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
